// File: rtl/bcd_ndigit_conv.sv
// Sequential binary-to-BCD converter (shift-add-3). Build option BCD_SATURATE_EN:
// when defined, an overflowing result is reported as all nines instead of value mod 10^DIGITS.
module bcd_ndigit_conv #(
  parameter int WIDTH  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      value,
  output logic                  ready,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = 4 * DIGITS;

  // Handshake: start is taken on any rising edge where ready is high; value is
  // captured on that same edge. done pulses once when bcd/overflow take a new result.
  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [BW-1:0]     dig_q, dig_d;
  logic [WIDTH-1:0]  opr_q, opr_d;
  logic              trk_q, trk_d;
  logic [BW-1:0]     bcd_q, bcd_d;
  logic              ovf_q, ovf_d;
  logic              done_q, done_d;
  logic [BW-1:0]     adj;
  logic [BW-1:0]     nines;

  always_comb begin
    adj   = '0;
    nines = '0;
    for (int i = 0; i < DIGITS; i++) begin
      adj[4*i +: 4]   = (dig_q[4*i +: 4] >= 4'd5) ? dig_q[4*i +: 4] + 4'd3 : dig_q[4*i +: 4];
      nines[4*i +: 4] = 4'd9;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dig_d   = dig_q;
    opr_d   = opr_q;
    trk_d   = trk_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          opr_d   = value;
          dig_d   = '0;
          trk_d   = 1'b0;
          cnt_d   = CW'(WIDTH);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q != '0) begin
          // A carry out of the top digit means the operand exceeds the digit range.
          trk_d = trk_q | adj[BW-1];
          dig_d = {adj[BW-2:0], opr_q[WIDTH-1]};
          opr_d = opr_q << 1;
          cnt_d = cnt_q - CW'(1);
        end else begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        state_d = IDLE;
        done_d  = 1'b1;
        ovf_d   = trk_q;
`ifdef BCD_SATURATE_EN
        bcd_d   = trk_q ? nines : dig_q;
`else
        bcd_d   = dig_q;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dig_q   <= '0;
      opr_q   <= '0;
      trk_q   <= 1'b0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dig_q   <= dig_d;
      opr_q   <= opr_d;
      trk_q   <= trk_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign ready    = (state_q == IDLE);
  assign done     = done_q;
  assign bcd      = bcd_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_bcd_ndigit_conv.sv
// Bench for bcd_ndigit_conv: a default-size instance and a WIDTH=8/DIGITS=2 instance,
// checked against a decimal reference model built from plain division.
module tb_bcd_ndigit_conv;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_start, a_ready, a_done, a_ovf;
  logic [13:0] a_value;
  logic [15:0] a_bcd;
  logic        b_start, b_ready, b_done, b_ovf;
  logic [7:0]  b_value;
  logic [7:0]  b_bcd;

  int compared   = 0;
  int mismatched = 0;

  logic [15:0] a_last_bcd = '0;
  logic        a_last_ovf = 1'b0;

  localparam int A_LAT = 16;
  localparam int B_LAT = 10;

  bcd_ndigit_conv dut_a (
    .clk(clk), .rst(rst), .start(a_start), .value(a_value),
    .ready(a_ready), .done(a_done), .bcd(a_bcd), .overflow(a_ovf)
  );

  bcd_ndigit_conv #(.WIDTH(8), .DIGITS(2)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .value(b_value),
    .ready(b_ready), .done(b_done), .bcd(b_bcd), .overflow(b_ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Decimal reference: digits of v mod 10^digits, overflow when v >= 10^digits.
  function automatic void ref_model(input longint unsigned v, input int digits,
                                    output logic [39:0] b, output logic o);
    longint unsigned p, m;
    p = 1;
    for (int i = 0; i < digits; i++) p = p * 10;
    o = (v >= p);
    m = v % p;
    b = '0;
    for (int i = 0; i < digits; i++) begin
      b[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
`ifdef BCD_SATURATE_EN
    if (o) for (int i = 0; i < digits; i++) b[4*i +: 4] = 4'd9;
`endif
  endfunction

  // Entered and left at #1 after a rising edge; returns right after the done edge.
  task automatic conv_a(input logic [13:0] v, input int extra_at, input logic [13:0] extra_v,
                        output int lat, output logic [15:0] b, output logic o);
    logic held;
    held = 1'b1; lat = -1; b = '0; o = 1'b0;
    a_start = 1'b1; a_value = v;
    @(posedge clk); #1;
    a_start = 1'b0; a_value = 14'($urandom);
    for (int n = 1; n <= 40; n++) begin
      if (n == extra_at) begin a_start = 1'b1; a_value = extra_v; end
      @(posedge clk); #1;
      a_start = 1'b0; a_value = 14'($urandom);
      if (a_done) begin lat = n; b = a_bcd; o = a_ovf; break; end
      if (a_bcd !== a_last_bcd || a_ovf !== a_last_ovf) held = 1'b0;
    end
    check("a_hold", 64'(held), 64'd1);
    if (lat >= 0) begin a_last_bcd = b; a_last_ovf = o; end
  endtask

  task automatic run_a(input logic [13:0] v, input int extra_at, input logic [13:0] extra_v);
    int lat; logic [15:0] b; logic o; logic [39:0] eb; logic eo;
    ref_model(longint'(v), 4, eb, eo);
    conv_a(v, extra_at, extra_v, lat, b, o);
    check($sformatf("a_lat_%0d", v), 64'(lat), 64'(A_LAT));
    check($sformatf("a_bcd_%0d", v), 64'(b), 64'(eb[15:0]));
    check($sformatf("a_ovf_%0d", v), 64'(o), 64'(eo));
    check($sformatf("a_ready_%0d", v), 64'(a_ready), 64'd1);
  endtask

  task automatic run_b(input logic [7:0] v);
    int lat; logic [7:0] b; logic o; logic [39:0] eb; logic eo;
    ref_model(longint'(v), 2, eb, eo);
    lat = -1; b = '0; o = 1'b0;
    b_start = 1'b1; b_value = v;
    @(posedge clk); #1;
    b_start = 1'b0; b_value = 8'($urandom);
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk); #1;
      b_value = 8'($urandom);
      if (b_done) begin lat = n; b = b_bcd; o = b_ovf; break; end
    end
    check($sformatf("b_lat_%0d", v), 64'(lat), 64'(B_LAT));
    check($sformatf("b_bcd_%0d", v), 64'(b), 64'(eb[7:0]));
    check($sformatf("b_ovf_%0d", v), 64'(o), 64'(eo));
    check($sformatf("b_ready_%0d", v), 64'(b_ready), 64'd1);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  initial begin
    int ndone;
    rst = 1'b1; a_start = 1'b0; a_value = '0; b_start = 1'b0; b_value = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 64'(a_ready), 64'd1);
    check("rst_done",  64'(a_done),  64'd0);
    check("rst_bcd",   64'(a_bcd),   64'd0);
    check("rst_ovf",   64'(a_ovf),   64'd0);
    check("rst_b_bcd", 64'(b_bcd),   64'd0);

    // Reset wins over a simultaneous start.
    a_start = 1'b1; a_value = 14'd777;
    @(posedge clk); #1;
    a_start = 1'b0; rst = 1'b0;
    check("rst_prio_ready", 64'(a_ready), 64'd1);

    run_a(14'd1234, 0, '0);
    idle_cycles(2);
    run_a(14'd16383, 0, '0);
    idle_cycles(1);
    run_a(14'd9999, 0, '0);
    run_a(14'd0, 0, '0);          // back-to-back: start while done is high
    idle_cycles(1);
    run_a(14'd10000, 0, '0);

    // Extra start mid-conversion must be ignored.
    run_a(14'd5678, 5, 14'd1);
    ndone = 0;
    for (int i = 0; i < 20; i++) begin @(posedge clk); #1; if (a_done) ndone++; end
    check("a_single_done", 64'(ndone), 64'd0);
    check("a_after_extra_bcd", 64'(a_bcd), 64'h5678);

    // Reset aborts a conversion in progress.
    a_start = 1'b1; a_value = 14'd4321;
    @(posedge clk); #1;
    a_start = 1'b0;
    for (int n = 1; n < 8; n++) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 25; i++) begin @(posedge clk); #1; if (a_done) ndone++; end
    check("abort_no_done", 64'(ndone), 64'd0);
    check("abort_bcd", 64'(a_bcd), 64'd0);
    check("abort_ovf", 64'(a_ovf), 64'd0);
    check("abort_ready", 64'(a_ready), 64'd1);
    a_last_bcd = '0; a_last_ovf = 1'b0;
    run_a(14'd42, 0, '0);

    for (int i = 0; i < 12; i++) begin
      run_a(14'($urandom_range(0, 16383)), 0, '0);
      idle_cycles($urandom_range(0, 3));
    end

    run_b(8'd255);
    idle_cycles(1);
    run_b(8'd99);
    run_b(8'd0);
    for (int i = 0; i < 6; i++) begin
      run_b(8'($urandom_range(0, 255)));
      idle_cycles($urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
